// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter that lets two producers share one FIFO write port.
// Each grant may carry up to BURST consecutive words. For every word it forwards, the
// arbiter returns a done (acknowledged) pulse or an err (wr_err) pulse to that requester.
// Optional feature macro: FIFO_ARB_FULL_GUARD_EN. When it is defined, no write is issued
// while f_full is high.
module fifo_wr_arbiter #(
    parameter int BURST = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic          f_wr_en,
    output logic [DW-1:0] f_d_in,
    input  logic          f_full,
    input  logic          f_wr_ack,
    input  logic          f_wr_err,
    output logic          busy,
    output logic          owner
);

    localparam int             BCW       = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_sel;
    logic           r_pri;
    logic [BCW-1:0] r_bcnt;
    logic           r_wr_en;
    logic [DW-1:0]  r_d_in;
    logic           r_gnt0;
    logic           r_gnt1;
    logic           r_done0;
    logic           r_done1;
    logic           r_err0;
    logic           r_err1;

    logic           w_issue;
    logic           w_start;
    logic           w_cont;
    logic           w_pick;
    logic           w_req_sel;
    logic           w_in_wait;

`ifdef FIFO_ARB_FULL_GUARD_EN
    // Hold off new words while the FIFO is full, so overflow can never be signalled.
    assign w_issue = !f_full;
`else
    // Always issue; an overflow surfaces as the FIFO's wr_err forwarded to the owner.
    assign w_issue = 1'b1;
`endif

    assign w_in_wait = (r_state == WAIT);

    // Next-state decode: new grant from IDLE, burst continuation from WAIT, otherwise release.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_cont    = 1'b0;
        w_pick    = r_pri;
        w_req_sel = r_sel ? req1 : req0;
        case (r_state)
            IDLE: begin
                // A lone requester wins outright; pri only breaks ties.
                w_pick = (req0 && req1) ? r_pri : req1;
                if ((req0 || req1) && w_issue) begin
                    w_next  = WR;
                    w_start = 1'b1;
                end
            end
            WR: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (w_req_sel && (r_bcnt < BCNT_LAST) && w_issue) begin
                    w_next = WR;
                    w_cont = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Ownership, priority and burst count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel  <= 1'b0;
            r_pri  <= 1'b0;
            r_bcnt <= '0;
        end else begin
            if (w_start) begin
                r_sel  <= w_pick;
                r_bcnt <= '0;
            end else if (w_cont) begin
                r_bcnt <= r_bcnt + BCW'(1);
            end
            // Hand preference to the other requester whenever a burst ends.
            if (w_in_wait && !w_cont) r_pri <= ~r_sel;
        end
    end

    // Registered FIFO write port and grant pulses; data is captured on the same edge as the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en <= 1'b0;
            r_d_in  <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
        end else begin
            r_wr_en <= w_start || w_cont;
            r_gnt0  <= (w_start && !w_pick) || (w_cont && !r_sel);
            r_gnt1  <= (w_start &&  w_pick) || (w_cont &&  r_sel);
            if (w_start)     r_d_in <= w_pick ? d1 : d0;
            else if (w_cont) r_d_in <= r_sel ? d1 : d0;
        end
    end

    // FIFO status sampled in WAIT and returned to the owner one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_done0 <= w_in_wait && !r_sel && f_wr_ack;
            r_done1 <= w_in_wait &&  r_sel && f_wr_ack;
            r_err0  <= w_in_wait && !r_sel && f_wr_err;
            r_err1  <= w_in_wait &&  r_sel && f_wr_err;
        end
    end

    assign f_wr_en = r_wr_en;
    assign f_d_in  = r_d_in;
    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign owner   = r_sel;
    assign busy    = (r_state != IDLE);

endmodule
